div_writeback: RTL and testbench

Result-capture and writeback stage directly downstream of the ALU divider. Accepts {quotient, remainder, divide-by-zero} results through a valid/ready handshake and buffers them in a small FIFO. Arbitrates for the shared 32-bit datapath bus and writes each result as two bus beats: quotient into LO, then remainder into HI. Keeps a sticky divide-by-zero status bit for the control unit.

---
 rtl/div_writeback.sv | 153 +++++++++++++++
 tb/tb_div_writeback.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_writeback.sv
// ============================================================================
//  Module      : div_writeback
//  Description : Divider result capture FIFO and two-beat writeback over the
//                shared datapath bus (quotient -> LO, remainder -> HI), with
//                a sticky divide-by-zero status bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_writeback #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         res_valid,
  output logic         res_ready,
  input  logic [W-1:0] quotient,
  input  logic [W-1:0] remainder,
  input  logic         div_by_zero,
  output logic         bus_req,
  input  logic         bus_grant,
  output logic [W-1:0] bus_data,
  output logic         lo_we,
  output logic         hi_we,
  output logic         dz_sticky,
  input  logic         dz_clr,
  output logic         busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WR_LO = 2'd2,
    WR_HI = 2'd3
  } state_t;

  state_t state;

  // FIFO storage and pointers; pointers carry one extra wrap bit
  logic [W-1:0]     q_mem [DEPTH];
  logic [W-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0] dz_mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic [W-1:0] head_q;
  logic [W-1:0] head_r;
  logic         head_dz;

  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Ready depends only on registered occupancy, so a pop never opens a
  // same-cycle push slot when the FIFO is full.
  assign res_ready = !full;
  assign push      = res_valid && !full;

  assign head_q  = q_mem[rd_ptr[AW-1:0]];
  assign head_r  = r_mem[rd_ptr[AW-1:0]];
  assign head_dz = dz_mem[rd_ptr[AW-1:0]];

  // Write enables follow the grant directly so a lost grant never writes
  assign lo_we = (state == WR_LO) && bus_grant;
  assign hi_we = (state == WR_HI) && bus_grant;
  assign pop   = hi_we;

  assign busy = !empty || (state != IDLE);

  // Result storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr[AW-1:0]]  <= quotient;
      r_mem[wr_ptr[AW-1:0]]  <= remainder;
      dz_mem[wr_ptr[AW-1:0]] <= div_by_zero;
    end
  end

  // FIFO pointer update
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Writeback sequencer; bus_data is loaded on entry to each write state so
  // it is held steady through any grant stall.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      bus_req  <= 1'b0;
      bus_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state   <= REQ;
            bus_req <= 1'b1;
          end
        end
        REQ: begin
          if (bus_grant) begin
            state    <= WR_LO;
            bus_data <= head_dz ? {W{1'b1}} : head_q;
          end
        end
        WR_LO: begin
          if (bus_grant) begin
            state    <= WR_HI;
            bus_data <= head_r;
          end
        end
        WR_HI: begin
          if (bus_grant) begin
            state    <= IDLE;
            bus_req  <= 1'b0;
            bus_data <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          bus_req  <= 1'b0;
          bus_data <= '0;
        end
      endcase
    end
  end

  // Sticky divide-by-zero flag; a set on the pop cycle beats a clear
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dz_sticky <= 1'b0;
    end else if (pop && head_dz) begin
      dz_sticky <= 1'b1;
    end else if (dz_clr) begin
      dz_sticky <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_writeback.sv
// ============================================================================
//  Module      : tb_div_writeback
//  Description : Self-checking bench for div_writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_writeback;

  localparam int DEPTH = 2;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         bus_req;
  logic         bus_grant;
  logic [W-1:0] bus_data;
  logic         lo_we;
  logic         hi_we;
  logic         dz_sticky;
  logic         dz_clr;
  logic         busy;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] lo_log[$];
  logic [W-1:0] hi_log[$];

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } res_t;

  div_writeback #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .clr_n(clr_n), .res_valid(res_valid), .res_ready(res_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_data(bus_data),
    .lo_we(lo_we), .hi_we(hi_we), .dz_sticky(dz_sticky), .dz_clr(dz_clr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Record every bus write, sampled mid-cycle
  always @(negedge clk) begin
    if (clr_n) begin
      if (lo_we) lo_log.push_back(bus_data);
      if (hi_we) hi_log.push_back(bus_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] exp_lo(input logic dz, input logic [W-1:0] q);
    return dz ? {W{1'b1}} : q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL wait_idle: busy got 1 want 0 within 60 cycles");
    end
    tick();
  endtask

  task automatic test_reset();
    clr_n = 1'b0; res_valid = 1'b1; bus_grant = 1'b1; dz_clr = 1'b0;
    quotient = $urandom; remainder = $urandom; div_by_zero = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", res_ready); end
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", bus_req); end
    total++; if (bus_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", bus_data); end
    total++; if (lo_we !== 1'b0 || hi_we !== 1'b0) begin bad++; $display("FAIL reset_we: got lo=%b hi=%b want 0", lo_we, hi_we); end
    total++; if (dz_sticky !== 1'b0) begin bad++; $display("FAIL reset_dz: got %b want 0", dz_sticky); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    tick();
    res_valid = 1'b0;
    clr_n = 1'b1;
    tick();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_nopush: busy got %b want 0", busy); end
    tick();
  endtask

  task automatic test_single();
    lo_log.delete(); hi_log.delete();
    bus_grant = 1'b1;
    res_valid = 1'b1; quotient = 32'h7; remainder = 32'h3; div_by_zero = 1'b0;
    tick();  // E0 push
    res_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      case (k)
        1: begin total++; if (busy !== 1'b1 || bus_req !== 1'b0) begin bad++; $display("FAIL single_k1: got busy=%b req=%b want 1/0", busy, bus_req); end end
        2: begin total++; if (bus_req !== 1'b1 || lo_we !== 1'b0) begin bad++; $display("FAIL single_k2: got req=%b lo=%b want 1/0", bus_req, lo_we); end end
        3: begin total++; if (lo_we !== 1'b1 || hi_we !== 1'b0 || bus_data !== 32'h7) begin bad++; $display("FAIL single_lo: got lo=%b hi=%b data=%h want 1/0/7", lo_we, hi_we, bus_data); end end
        4: begin total++; if (hi_we !== 1'b1 || lo_we !== 1'b0 || bus_data !== 32'h3) begin bad++; $display("FAIL single_hi: got hi=%b lo=%b data=%h want 1/0/3", hi_we, lo_we, bus_data); end end
        default: begin total++; if (busy !== 1'b0 || bus_data !== '0 || bus_req !== 1'b0) begin bad++; $display("FAIL single_idle: got busy=%b data=%h req=%b want 0/0/0", busy, bus_data, bus_req); end end
      endcase
      tick();
    end
  endtask

  task automatic test_backpressure();
    res_t v[3];
    bit seen = 0;
    lo_log.delete(); hi_log.delete();
    bus_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v[i].q = $urandom; v[i].r = $urandom; v[i].dz = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      res_valid = 1'b1; quotient = v[i].q; remainder = v[i].r; div_by_zero = 1'b0;
      @(negedge clk);
      total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL bp_accept%0d: ready got %b want 1", i, res_ready); end
      tick();
    end
    quotient = v[2].q; remainder = v[2].r;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (res_ready !== 1'b0 || lo_we !== 1'b0 || hi_we !== 1'b0) begin bad++; $display("FAIL bp_full%0d: got ready=%b lo=%b hi=%b want 0/0/0", c, res_ready, lo_we, hi_we); end
      tick();
    end
    bus_grant = 1'b1;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (res_ready) seen = 1;
      else tick();
    end
    total++; if (!seen) begin bad++; $display("FAIL bp_reopen: ready got 0 want 1 within 30 cycles"); end
    total++; if (hi_log.size() != 1) begin bad++; $display("FAIL bp_reopen_pop: pops got %0d want 1", hi_log.size()); end
    tick();
    res_valid = 1'b0;
    wait_idle();
    total++; if (lo_log.size() != 3 || hi_log.size() != 3) begin bad++; $display("FAIL bp_count: got lo=%0d hi=%0d want 3/3", lo_log.size(), hi_log.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (lo_log[i] !== v[i].q || hi_log[i] !== v[i].r) begin bad++; $display("FAIL bp_order%0d: got %h/%h want %h/%h", i, lo_log[i], hi_log[i], v[i].q, v[i].r); end
      end
    end
  endtask

  task automatic test_dz();
    bit seen = 0;
    lo_log.delete(); hi_log.delete();
    bus_grant = 1'b1; dz_clr = 1'b0;
    res_valid = 1'b1; quotient = 32'h1234; remainder = 32'hABCD; div_by_zero = 1'b1;
    tick();
    res_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    total++; if (lo_log.size() != 1 || lo_log[0] !== exp_lo(1'b1, 32'h1234)) begin bad++; $display("FAIL dz_lo: got n=%0d want FFFFFFFF", lo_log.size()); end
    total++; if (hi_log.size() != 1 || hi_log[0] !== 32'hABCD) begin bad++; $display("FAIL dz_hi: got n=%0d want ABCD", hi_log.size()); end
    total++; if (dz_sticky !== 1'b1) begin bad++; $display("FAIL dz_set: got %b want 1", dz_sticky); end
    tick();
    dz_clr = 1'b1;
    tick();
    dz_clr = 1'b0;
    @(negedge clk);
    total++; if (dz_sticky !== 1'b0) begin bad++; $display("FAIL dz_clear: got %b want 0", dz_sticky); end
    tick();
    res_valid = 1'b1; quotient = $urandom; remainder = $urandom; div_by_zero = 1'b1;
    tick();
    res_valid = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (hi_we) seen = 1;
      else tick();
    end
    total++; if (!seen) begin bad++; $display("FAIL dz_pop2: hi_we got 0 want 1 within 20 cycles"); end
    dz_clr = 1'b1;
    tick();
    dz_clr = 1'b0;
    @(negedge clk);
    total++; if (dz_sticky !== 1'b1) begin bad++; $display("FAIL dz_setwins: got %b want 1", dz_sticky); end
    tick();
  endtask

  task automatic test_stall();
    logic [W-1:0] q, r;
    q = $urandom; r = $urandom;
    lo_log.delete(); hi_log.delete();
    bus_grant = 1'b0;
    res_valid = 1'b1; quotient = q; remainder = r; div_by_zero = 1'b0;
    tick();
    res_valid = 1'b0;
    repeat (3) tick();
    bus_grant = 1'b1;
    tick();            // enters WR_LO
    bus_grant = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (lo_we !== 1'b0 || bus_req !== 1'b1 || bus_data !== q) begin bad++; $display("FAIL stall_lo%0d: got lo=%b req=%b data=%h want 0/1/%h", c, lo_we, bus_req, bus_data, q); end
      tick();
    end
    bus_grant = 1'b1;
    @(negedge clk);
    total++; if (lo_we !== 1'b1 || bus_data !== q) begin bad++; $display("FAIL stall_lo_go: got lo=%b data=%h want 1/%h", lo_we, bus_data, q); end
    tick();            // enters WR_HI
    bus_grant = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (hi_we !== 1'b0 || bus_req !== 1'b1 || bus_data !== r) begin bad++; $display("FAIL stall_hi%0d: got hi=%b req=%b data=%h want 0/1/%h", c, hi_we, bus_req, bus_data, r); end
      tick();
    end
    bus_grant = 1'b1;
    @(negedge clk);
    total++; if (hi_we !== 1'b1 || bus_data !== r) begin bad++; $display("FAIL stall_hi_go: got hi=%b data=%h want 1/%h", hi_we, bus_data, r); end
    tick();
    wait_idle();
    total++; if (lo_log.size() != 1 || hi_log.size() != 1) begin bad++; $display("FAIL stall_pulses: got lo=%0d hi=%0d want 1/1", lo_log.size(), hi_log.size()); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    lo_log.delete(); hi_log.delete();
    bus_grant = 1'b1; div_by_zero = 1'b0;
    res_valid = 1'b1; quotient = $urandom; remainder = $urandom;
    tick();
    quotient = $urandom; remainder = $urandom;
    tick();
    res_valid = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (lo_we) seen = 1;
      else tick();
    end
    total++; if (!seen) begin bad++; $display("FAIL rmid_lo: lo_we got 0 want 1 within 20 cycles"); end
    @(posedge clk);
    #1;
    clr_n = 1'b0; bus_grant = 1'b0;
    @(negedge clk);
    total++; if (hi_we !== 1'b0 || busy !== 1'b0 || res_ready !== 1'b1) begin bad++; $display("FAIL rmid_inreset: got hi=%b busy=%b ready=%b want 0/0/1", hi_we, busy, res_ready); end
    tick();
    clr_n = 1'b1; bus_grant = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++; if (busy !== 1'b0 || lo_we !== 1'b0 || hi_we !== 1'b0) begin bad++; $display("FAIL rmid_after%0d: got busy=%b lo=%b hi=%b want 0/0/0", c, busy, lo_we, hi_we); end
      tick();
    end
    total++; if (hi_log.size() != 0 || lo_log.size() != 1) begin bad++; $display("FAIL rmid_log: got lo=%0d hi=%0d want 1/0", lo_log.size(), hi_log.size()); end
  endtask

  // Transaction-level model: occupancy counts, ordered expected results,
  // and the sticky flag rule
  task automatic test_random();
    res_t exp_q[$];
    res_t f;
    int pushed = 0, popped = 0;
    bit lo_seen = 0;
    bit mstk = 0;
    bit drain;
    for (int c = 0; c < 480; c++) begin
      drain = (c >= 400);
      res_valid   = drain ? 1'b0 : ($urandom_range(0, 99) < 60);
      quotient    = $urandom;
      remainder   = $urandom;
      div_by_zero = ($urandom_range(0, 3) == 0);
      bus_grant   = drain ? 1'b1 : ($urandom_range(0, 99) < 75);
      dz_clr      = drain ? 1'b0 : ($urandom_range(0, 9) == 0);
      @(negedge clk);
      total++; if (res_ready !== ((pushed - popped) < DEPTH)) begin bad++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, res_ready, (pushed - popped) < DEPTH); end
      total++; if ((lo_we && hi_we) || ((lo_we || hi_we) && !bus_grant)) begin bad++; $display("FAIL rnd_we c=%0d: got lo=%b hi=%b grant=%b want exclusive and granted", c, lo_we, hi_we, bus_grant); end
      total++; if (dz_sticky !== mstk) begin bad++; $display("FAIL rnd_dz c=%0d: got %b want %b", c, dz_sticky, mstk); end
      if (lo_we) begin
        total++;
        if (exp_q.size() == 0 || lo_seen) begin bad++; $display("FAIL rnd_lo_unexp c=%0d: got write want none", c); end
        else begin
          if (bus_data !== exp_lo(exp_q[0].dz, exp_q[0].q)) begin bad++; $display("FAIL rnd_lo c=%0d: got %h want %h", c, bus_data, exp_lo(exp_q[0].dz, exp_q[0].q)); end
          lo_seen = 1;
        end
      end
      if (dz_clr) mstk = 0;
      if (hi_we) begin
        total++;
        if (exp_q.size() == 0 || !lo_seen) begin bad++; $display("FAIL rnd_hi_unexp c=%0d: got write want none", c); end
        else begin
          f = exp_q.pop_front();
          if (bus_data !== f.r) begin bad++; $display("FAIL rnd_hi c=%0d: got %h want %h", c, bus_data, f.r); end
          if (f.dz) mstk = 1;
          popped++;
          lo_seen = 0;
        end
      end
      if (res_valid && res_ready) begin
        f.q = quotient; f.r = remainder; f.dz = div_by_zero;
        exp_q.push_back(f);
        pushed++;
      end
      tick();
    end
    @(negedge clk);
    total++; if (exp_q.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL rnd_drain: got left=%0d busy=%b want 0/0", exp_q.size(), busy); end
    tick();
  endtask

  initial begin
    clr_n = 1'b0; res_valid = 1'b0; quotient = '0; remainder = '0;
    div_by_zero = 1'b0; bus_grant = 1'b0; dz_clr = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_dz();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
